// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and, later, the receiver.
//   uart_state_t   : frame-level states (IDLE, START, DATA, PARITY, STOP)
//   PAR_*          : parity_mode encodings (2'b11 is treated as none)
//   parity_enabled : 1 when a mode inserts a parity bit
//   parity_bit     : parity bit from the XOR of the data word and the mode
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // data_xor is the XOR-reduction of the data word; odd parity inverts it.
    function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter.
// Sends start bit, DBITS data bits LSB first, optional parity bit and one or
// two stop bits. Bit timing comes from sample_tick (OVS ticks per bit).
// Ports:
//   clk_100MHz  in   system clock
//   reset       in   asynchronous active-high reset
//   sample_tick in   oversampling strobe from the baud-rate generator
//   tx_valid    in   frame request (accepted with tx_ready)
//   tx_data     in   data word, DBITS wide
//   parity_mode in   00 none, 01 even, 10 odd, 11 none
//   stop2       in   1 = two stop bits
//   tx_ready    out  high only in IDLE
//   tx          out  registered serial line, idle high
//   tx_busy     out  high whenever not IDLE
//   tx_done     out  one-clock pulse at the end of the stop period
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DBITS = 8,
    parameter int OVS   = 16
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             sample_tick,
    input  logic             tx_valid,
    input  logic [DBITS-1:0] tx_data,
    input  logic [1:0]       parity_mode,
    input  logic             stop2,
    output logic             tx_ready,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done
);

    // Tick counter must reach 2*OVS-1 for a double stop period.
    localparam int TW = $clog2(2 * OVS);
    localparam int BW = $clog2(DBITS);

    localparam logic [TW-1:0] BIT_LAST   = TW'(OVS - 1);
    localparam logic [TW-1:0] STOP2_LAST = TW'(2 * OVS - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DBITS - 1);

    uart_state_t      state_reg;
    logic [TW-1:0]    tick_cnt_reg;
    logic [BW-1:0]    bit_cnt_reg;
    logic [DBITS-1:0] shift_reg;
    logic [1:0]       mode_reg;
    logic             stop2_reg;
    logic             par_bit_reg;
    logic             tx_reg;
    logic             tx_done_reg;

    logic             bit_end;
    logic             stop_end;

    // A START/DATA/PARITY bit closes on the tick that hits OVS-1.
    assign bit_end  = sample_tick && (tick_cnt_reg == BIT_LAST);
    assign stop_end = sample_tick &&
                      (tick_cnt_reg == (stop2_reg ? STOP2_LAST : BIT_LAST));

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            mode_reg     <= PAR_NONE;
            stop2_reg    <= 1'b0;
            par_bit_reg  <= 1'b0;
            tx_reg       <= 1'b1;
            tx_done_reg  <= 1'b0;
        end else begin
            tx_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    tx_reg <= 1'b1;
                    if (tx_valid) begin
                        // Latch everything the frame depends on so later
                        // input changes cannot disturb it.
                        shift_reg    <= tx_data;
                        mode_reg     <= parity_mode;
                        stop2_reg    <= stop2;
                        par_bit_reg  <= parity_bit(parity_mode, ^tx_data);
                        tick_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        state_reg    <= ST_START;
                        tx_reg       <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        tick_cnt_reg <= '0;
                        state_reg    <= ST_DATA;
                        tx_reg       <= shift_reg[0];
                    end else if (sample_tick) begin
                        tick_cnt_reg <= tick_cnt_reg + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        tick_cnt_reg <= '0;
                        shift_reg    <= shift_reg >> 1;
                        if (bit_cnt_reg == DATA_LAST) begin
                            bit_cnt_reg <= '0;
                            if (parity_enabled(mode_reg)) begin
                                state_reg <= ST_PARITY;
                                tx_reg    <= par_bit_reg;
                            end else begin
                                state_reg <= ST_STOP;
                                tx_reg    <= 1'b1;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BW'(1);
                            // Next data bit is the one about to shift into bit 0.
                            tx_reg      <= shift_reg[1];
                        end
                    end else if (sample_tick) begin
                        tick_cnt_reg <= tick_cnt_reg + TW'(1);
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        tick_cnt_reg <= '0;
                        state_reg    <= ST_STOP;
                        tx_reg       <= 1'b1;
                    end else if (sample_tick) begin
                        tick_cnt_reg <= tick_cnt_reg + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (stop_end) begin
                        tick_cnt_reg <= '0;
                        state_reg    <= ST_IDLE;
                        tx_reg       <= 1'b1;
                        tx_done_reg  <= 1'b1;
                    end else if (sample_tick) begin
                        tick_cnt_reg <= tick_cnt_reg + TW'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

    assign tx       = tx_reg;
    assign tx_done  = tx_done_reg;
    assign tx_ready = (state_reg == ST_IDLE);
    assign tx_busy  = (state_reg != ST_IDLE);

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter DBITS SHALL default to 8; data bits per frame, legal range 5..9.
REQ-002 Parameter OVS SHALL default to 16; sample_ticks per bit period, legal range 8..32.
REQ-003 clk_100MHz  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 sample_tick  in  1  oversampling strobe from the baud-rate generator, at most one clock wide.
REQ-006 tx_valid  in  1  frame request.
REQ-007 tx_data  in  DBITS  data word, transmitted LSB first.
REQ-008 parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-009 stop2  in  1  1 selects two stop bits, 0 selects one.
REQ-010 tx_ready  out  1  high only in IDLE; a frame is accepted when tx_valid and tx_ready are both high on a clock edge.
REQ-011 tx  out  1  serial line, registered, idle-high.
REQ-012 tx_busy  out  1  high in every state except IDLE.
REQ-013 tx_done  out  1  one-clock pulse at the end of the stop period.

Function
REQ-014 States SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-015 On accept, the block SHALL register tx_data, parity_mode and stop2, clear the tick counter, and enter START on the next edge.
REQ-016 Input changes after accept SHALL NOT affect the frame in flight.
REQ-017 tx SHALL take the new state's line level on the same edge the state is entered: START 0, DATA current LSB of the shift register, PARITY the parity bit, STOP 1, IDLE 1.
REQ-018 The tick counter SHALL advance only on sample_tick; sample_tick SHALL be ignored in IDLE.
REQ-019 Each START, DATA and PARITY bit SHALL end on the sample_tick at which the tick counter equals OVS-1; the counter then clears.
REQ-020 DATA SHALL shift right once per bit and leave after DBITS bits: to PARITY when the latched mode is even or odd, otherwise to STOP.
REQ-021 The parity bit SHALL be the XOR of the latched data for even mode and its inverse for odd mode.
REQ-022 STOP SHALL last OVS ticks, or 2*OVS ticks when the latched stop2 is 1; it ends on the tick at which the counter equals that length minus 1.
REQ-023 At the end of STOP, the block SHALL return to IDLE and pulse tx_done for exactly one clock.
REQ-024 A new frame SHALL be acceptable on the first clock after tx_done, with no extra idle bit between frames.
REQ-025 tx_valid while busy SHALL be ignored, with no queuing.
REQ-026 The tick counter SHALL be $clog2(2*OVS) bits wide and the bit counter $clog2(DBITS) bits wide; neither SHALL wrap within a frame.

Reset
REQ-027 Reset SHALL force IDLE asynchronously, with tx=1, tx_ready=1, tx_busy=0, tx_done=0, and counters and shift register at 0.
REQ-028 Reset mid-frame SHALL abort the frame immediately with no tx_done pulse.

Structure
REQ-029 State encoding and the parity-mode constants PAR_NONE, PAR_EVEN and PAR_ODD SHALL live in shared package uart_pkg, for reuse by the receiver.
REQ-030 The block SHALL be a single module with no sub-module; sample_tick comes from the baud-rate generator outside the block.

Verification (DBITS=8, OVS=16, sample_tick every 4 clocks)
REQ-031 Send 0xA5, parity none, stop2=0 -> tx reads 0,1,0,1,0,0,1,0,1,1, 16 ticks per bit; tx_done pulses after 160 ticks.
REQ-032 Send 0x07 even, then 0x07 odd -> parity bit is 1, then 0; each frame is 11 bits.
REQ-033 Send 0x00, none, stop2=1 -> stop level lasts 32 ticks; tx_done pulses after 176 ticks.
REQ-034 Hold tx_valid high with 0x55 then 0xAA -> second START begins the clock after tx_done; tx_ready stays low throughout each frame.
REQ-035 Assert reset during DATA bit 3 -> tx=1 at once, tx_ready=1 after release, no tx_done pulse.
REQ-036 Change parity_mode and stop2 and pulse tx_valid mid-frame -> frame bits are unchanged and no second frame is accepted.
